// File: rtl/aes_round_ctrl_if.sv
// Handshake and control bundle between the AES round sequencer and its user/datapath.
// master drives start and observes; slave is the sequencer itself.
interface aes_round_ctrl_if;
   logic       start;
   logic       state_en;
   logic       state_sel;
   logic       key_en;
   logic       key_sel;
   logic [7:0] rcon;
   logic [3:0] round;
   logic       last_round;
   logic       busy;
   logic       done;

   modport master (
      output start,
      input  state_en, state_sel, key_en, key_sel, rcon, round, last_round, busy, done
   );

   modport slave (
      input  start,
      output state_en, state_sel, key_en, key_sel, rcon, round, last_round, busy, done
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the round-based masked AES-128 core: load, wait for the S-box
// pipeline, commit each round, and generate rcon / last-round flag.
module aes_round_ctrl #(
   parameter int unsigned NR       = 10,
   parameter int unsigned SBOX_LAT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   aes_round_ctrl_if.slave  ctrl
);

   localparam int unsigned CntW     = (SBOX_LAT > 2) ? $clog2(SBOX_LAT) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'((SBOX_LAT >= 2) ? (SBOX_LAT - 2) : 0);
   localparam logic [3:0]  LastRound = 4'(NR);
   localparam bit          NoWait    = (SBOX_LAT == 1);

   typedef enum logic [2:0] {StIdle, StLoad, StWait, StUpdate, StDone} state_e;

   state_e          state_q, state_d;
   logic [3:0]      round_q, round_d;
   logic [7:0]      rcon_q, rcon_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         round_q <= 4'd0;
         rcon_q  <= 8'h01;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (ctrl.start) begin
               state_d = StLoad;
               round_d = 4'd0;
               rcon_d  = 8'h01;
            end
         end
         StLoad: begin
            round_d = 4'd1;
            rcon_d  = 8'h01;
            cnt_d   = CntInit;
            state_d = NoWait ? StUpdate : StWait;
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StUpdate;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StUpdate: begin
            if (round_q == LastRound) begin
               state_d = StDone;
            end else begin
               round_d = round_q + 4'd1;
               rcon_d  = xtime(rcon_q);
               cnt_d   = CntInit;
               state_d = NoWait ? StUpdate : StWait;
            end
         end
         StDone: begin
            // Return round/rcon to their reset values so IDLE looks the same after every run.
            state_d = StIdle;
            round_d = 4'd0;
            rcon_d  = 8'h01;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ctrl.state_en  = 1'b0;
      ctrl.state_sel = 1'b0;
      ctrl.key_en    = 1'b0;
      ctrl.key_sel   = 1'b0;
      ctrl.busy      = 1'b0;
      ctrl.done      = 1'b0;
      unique case (state_q)
         StLoad: begin
            ctrl.state_en = 1'b1;
            ctrl.key_en   = 1'b1;
            ctrl.busy     = 1'b1;
         end
         StWait: ctrl.busy = 1'b1;
         StUpdate: begin
            ctrl.state_en  = 1'b1;
            ctrl.state_sel = 1'b1;
            ctrl.key_en    = 1'b1;
            ctrl.key_sel   = 1'b1;
            ctrl.busy      = 1'b1;
         end
         StDone: ctrl.done = 1'b1;
         default: ;
      endcase
   end

   assign ctrl.round      = round_q;
   assign ctrl.rcon       = rcon_q;
   assign ctrl.last_round = ctrl.busy & (round_q == LastRound);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench: three sequencer configurations share clock, reset and start and are
// compared every cycle against a cycle-offset timeline model.
module tb_aes_round_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic start;

   always #5 clk = ~clk;

   aes_round_ctrl_if if_a ();
   aes_round_ctrl_if if_b ();
   aes_round_ctrl_if if_c ();

   assign if_a.start = start;
   assign if_b.start = start;
   assign if_c.start = start;

   aes_round_ctrl #(.NR(10), .SBOX_LAT(4)) u_a (.clk(clk), .rst_n(rst_n), .ctrl(if_a.slave));
   aes_round_ctrl #(.NR(10), .SBOX_LAT(1)) u_b (.clk(clk), .rst_n(rst_n), .ctrl(if_b.slave));
   aes_round_ctrl #(.NR(3),  .SBOX_LAT(2)) u_c (.clk(clk), .rst_n(rst_n), .ctrl(if_c.slave));

   wire [6:0] fl_a = {if_a.state_en, if_a.state_sel, if_a.key_en, if_a.key_sel,
                      if_a.busy, if_a.done, if_a.last_round};
   wire [6:0] fl_b = {if_b.state_en, if_b.state_sel, if_b.key_en, if_b.key_sel,
                      if_b.busy, if_b.done, if_b.last_round};
   wire [6:0] fl_c = {if_c.state_en, if_c.state_sel, if_c.key_en, if_c.key_sel,
                      if_c.busy, if_c.done, if_c.last_round};

   logic [7:0] rcon_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   int ntests = 0;
   int nfail  = 0;
   // Cycles since the start-sampling edge (1 = LOAD); -1 while idle.
   int t_a = -1;
   int t_b = -1;
   int t_c = -1;

   function automatic int adv(input int t, input int nr, input int lat, input logic s);
      if (t < 0) return s ? 1 : -1;
      if (t == nr * lat + 2) return -1;
      return t + 1;
   endfunction

   task automatic chk(input string tag, input int t, input int nr, input int lat,
                      input logic [6:0] fl, input logic [3:0] rnd, input logic [7:0] rc);
      logic load, upd, busy, done, last;
      logic [6:0] exp_fl;
      int r;
      load = (t == 1);
      busy = (t >= 1) && (t <= nr * lat + 1);
      upd  = (t >= 2) && busy && (((t - 1) % lat) == 0);
      done = (t == nr * lat + 2);
      r    = (t >= 2) ? ((t - 2) / lat + 1) : 0;
      last = busy && (r == nr);
      exp_fl = {load | upd, upd, load | upd, upd, busy, done, last};
      ntests++;
      assert (fl === exp_fl) else begin
         nfail++;
         $error("FAIL %s flags t=%0d observed=%b expected=%b", tag, t, fl, exp_fl);
      end
      if (busy) begin
         ntests++;
         assert (rnd === 4'(r)) else begin
            nfail++;
            $error("FAIL %s round t=%0d observed=%0d expected=%0d", tag, t, rnd, r);
         end
         if (r >= 1) begin
            ntests++;
            assert (rc === rcon_tab[r]) else begin
               nfail++;
               $error("FAIL %s rcon t=%0d observed=%h expected=%h", tag, t, rc, rcon_tab[r]);
            end
         end
      end
   endtask

   task automatic chk_rst(input string tag, input logic [6:0] fl, input logic [3:0] rnd,
                          input logic [7:0] rc);
      ntests++;
      assert ({fl, rnd, rc} === {7'b0, 4'd0, 8'h01}) else begin
         nfail++;
         $error("FAIL %s reset observed=%b/%0d/%h expected=0000000/0/01", tag, fl, rnd, rc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (!rst_n) begin
         chk_rst("a_rst", fl_a, if_a.round, if_a.rcon);
         chk_rst("b_rst", fl_b, if_b.round, if_b.rcon);
         chk_rst("c_rst", fl_c, if_c.round, if_c.rcon);
      end else begin
         chk("a", t_a, 10, 4, fl_a, if_a.round, if_a.rcon);
         chk("b", t_b, 10, 1, fl_b, if_b.round, if_b.rcon);
         chk("c", t_c, 3,  2, fl_c, if_c.round, if_c.rcon);
      end
      @(posedge clk);
      if (rst_n) begin
         t_a = adv(t_a, 10, 4, start);
         t_b = adv(t_b, 10, 1, start);
         t_c = adv(t_c, 3,  2, start);
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      // Reset held with start toggling.
      for (int i = 0; i < 6; i++) begin
         start = 1'($urandom_range(0, 1));
         step();
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();

      // Single run from a one-cycle start pulse.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 46; i++) step();

      // start held high: back-to-back runs, period 43 for the default config.
      start = 1'b1;
      for (int i = 0; i < 95; i++) step();
      start = 1'b0;
      for (int i = 0; i < 45; i++) step();

      // Sparse random start requests, ignored while busy.
      for (int i = 0; i < 300; i++) begin
         start = ($urandom_range(0, 7) == 0);
         step();
      end
      start = 1'b0;
      for (int i = 0; i < 45; i++) step();

      // Asynchronous abort in the middle of cycle 20.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40 && t_a < 20; i++) step();
      #2 rst_n = 1'b0;
      #1;
      ntests++;
      assert ({if_a.busy, if_a.state_en, if_a.key_en, if_b.busy, if_c.busy} === 5'b0) else begin
         nfail++;
         $error("FAIL abort observed=%b expected=00000",
                {if_a.busy, if_a.state_en, if_a.key_en, if_b.busy, if_c.busy});
      end
      t_a = -1;
      t_b = -1;
      t_c = -1;
      for (int i = 0; i < 4; i++) step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 46; i++) step();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
